// File: rtl/turbo_itl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : turbo_itl_pkg
//  Description : Shared types and constants for the turbo interleaver RX
//                buffer sequencer (PB sizes, bank states, length helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package turbo_itl_pkg;

    // Physical block size selector as presented on the pb_size port
    typedef enum logic [1:0] {
        PB16    = 2'd0,
        PB136   = 2'd1,
        PB520   = 2'd2,
        PB_RSVD = 2'd3
    } pb_size_t;

    // Block lengths in 2-bit pairs
    localparam logic [15:0] C_LEN_PB16  = 16'd64;
    localparam logic [15:0] C_LEN_PB136 = 16'd544;
    localparam logic [15:0] C_LEN_PB520 = 16'd2080;

    // Life cycle of one ping-pong bank
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    // Pair count of a block; the reserved code maps to zero length
    function automatic logic [15:0] pb_len(input pb_size_t sz);
        case (sz)
            PB16:    return C_LEN_PB16;
            PB136:   return C_LEN_PB136;
            PB520:   return C_LEN_PB520;
            default: return 16'd0;
        endcase
    endfunction

    // Each RAM word carries four pairs
    function automatic logic [15:0] len_to_words(input logic [15:0] len);
        return len >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/itl_bank_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : itl_bank_fsm
//  Description : State machine for one ping-pong bank:
//                EMPTY -> FILLING -> FULL -> READING -> EMPTY.
//  Revision    : 1.0 - initial release
// ============================================================================
module itl_bank_fsm
    import turbo_itl_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic fill_start,   // first pair of a block accepted into this bank
    input  logic fill_done,    // last pair of the block written this cycle
    input  logic rd_start,     // read-out of this bank accepted this cycle
    input  logic rd_end,       // last read word of this bank issued this cycle
    output logic empty,
    output logic writable,
    output logic full
);

    bank_state_t r_state;
    bank_state_t w_next;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= BANK_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a start may land in the same cycle the bank completes
    always_comb begin
        w_next = r_state;
        case (r_state)
            BANK_EMPTY:   if (fill_start) w_next = BANK_FILLING;
            BANK_FILLING: if (fill_done)  w_next = rd_start ? BANK_READING : BANK_FULL;
            BANK_FULL:    if (rd_start)   w_next = BANK_READING;
            BANK_READING: if (rd_end)     w_next = BANK_EMPTY;
            default:                      w_next = BANK_EMPTY;
        endcase
    end

    // Status decode for the top-level arbitration
    always_comb begin
        empty    = (r_state == BANK_EMPTY);
        writable = (r_state == BANK_EMPTY) || (r_state == BANK_FILLING);
        full     = (r_state == BANK_FULL);
    end

endmodule
`default_nettype wire

// File: rtl/turbo_itl_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : turbo_itl_ctrl
//  Description : Ping-pong sequencer for the HPGP turbo interleaver RX buffer.
//                Fills one bank from the pair stream while the other bank is
//                read out as 4-pair words. Optional statistics counters are
//                enabled by defining ITL_CTRL_STAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module turbo_itl_ctrl
    import turbo_itl_pkg::*;
#(
    parameter int AW     = 12,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [1:0]    pb_size,
    input  logic          din_vld,
    input  logic          start,
    input  logic          mod_int_dint,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [AW-3:0] rd_idx,
    output logic          rd_mode,
    output logic          dout_vld,
    output logic          done,
    output logic          ovf,
    output logic          start_err
`ifdef ITL_CTRL_STAT_EN
    ,
    output logic [15:0]   blk_cnt,
    output logic [15:0]   drop_cnt
`endif
);

    localparam int C_IW = AW - 2;

    logic [1:0]      w_empty, w_writable, w_full_st, w_full;
    logic [1:0]      w_fill_start, w_fill_done, w_rd_start, w_rd_end;
    logic            w_cur_empty, w_cur_writable, w_oth_empty;
    logic            w_wr_en, w_wr_last, w_drop;
    logic [AW-1:0]   w_new_len_m1, w_len_m1;
    logic [C_IW-1:0] w_new_words_m1;
    logic            w_sel, w_start_ok, w_rd_last;

    logic            r_wr_bank;
    logic [AW-1:0]   r_wr_cnt, r_wr_len_m1;
    logic [C_IW-1:0] r_words_m1 [2];
    logic            r_rd_active, r_rd_bank, r_rd_mode, r_oldest;
    logic [C_IW-1:0] r_rd_idx, r_rd_last;
    logic [RD_LAT-1:0] r_vld_sr, r_last_sr;
    logic            r_ovf, r_start_err;

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            itl_bank_fsm u_fsm (
                .clk        (clk),
                .n_rst      (n_rst),
                .fill_start (w_fill_start[b]),
                .fill_done  (w_fill_done[b]),
                .rd_start   (w_rd_start[b]),
                .rd_end     (w_rd_end[b]),
                .empty      (w_empty[b]),
                .writable   (w_writable[b]),
                .full       (w_full_st[b])
            );
            assign w_fill_start[b] = w_wr_en & (r_wr_bank == 1'(b)) & w_cur_empty;
            assign w_fill_done[b]  = w_wr_last & (r_wr_bank == 1'(b));
            assign w_rd_start[b]   = w_start_ok & (w_sel == 1'(b));
            assign w_rd_end[b]     = w_rd_last & (r_rd_bank == 1'(b));
        end
    endgenerate

    // Write-side decode: length is taken from pb_size only on a block's first pair
    always_comb begin
        w_cur_empty    = w_empty[r_wr_bank];
        w_cur_writable = w_writable[r_wr_bank];
        w_oth_empty    = w_empty[~r_wr_bank];
        w_new_len_m1   = AW'(pb_len(pb_size_t'(pb_size)) - 16'd1);
        w_new_words_m1 = C_IW'(len_to_words(pb_len(pb_size_t'(pb_size))) - 16'd1);
        w_len_m1       = w_cur_empty ? w_new_len_m1 : r_wr_len_m1;
        w_wr_en        = din_vld & w_cur_writable &
                         ~(w_cur_empty & (pb_size_t'(pb_size) == PB_RSVD));
        w_wr_last      = w_wr_en & (r_wr_cnt == w_len_m1);
        w_drop         = din_vld & ~w_wr_en;
    end

    // Read-side decode: a bank completing this cycle already counts as FULL
    always_comb begin
        w_full     = w_full_st | w_fill_done;
        w_sel      = (&w_full) ? r_oldest : w_full[1];
        w_start_ok = start & ~r_rd_active & (|w_full);
        w_rd_last  = r_rd_active & (r_rd_idx == r_rd_last);
    end

    // Write counter, length latch and bank hand-over (stalls until the other bank drains)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_bank     <= 1'b0;
            r_wr_cnt      <= '0;
            r_wr_len_m1   <= '0;
            r_words_m1[0] <= '0;
            r_words_m1[1] <= '0;
        end else begin
            if (w_wr_en) begin
                if (w_cur_empty) begin
                    r_wr_len_m1           <= w_new_len_m1;
                    r_words_m1[r_wr_bank] <= w_new_words_m1;
                end
                r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + AW'(1);
            end
            if ((~w_cur_writable | w_wr_last) & w_oth_empty) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Read sequencer and oldest-FULL tracking
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rd_active <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_rd_mode   <= 1'b0;
            r_rd_idx    <= '0;
            r_rd_last   <= '0;
            r_oldest    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_rd_active <= 1'b1;
                r_rd_bank   <= w_sel;
                r_rd_mode   <= mod_int_dint;
                r_rd_idx    <= '0;
                r_rd_last   <= r_words_m1[w_sel];
            end else if (r_rd_active) begin
                r_rd_active <= ~w_rd_last;
                r_rd_idx    <= w_rd_last ? '0 : r_rd_idx + C_IW'(1);
            end
            if (w_fill_done[0] & ~w_full_st[1]) begin
                r_oldest <= 1'b0;
            end else if (w_fill_done[1] & ~w_full_st[0]) begin
                r_oldest <= 1'b1;
            end
        end
    end

    // RAM latency alignment for dout_vld and the end-of-block marker
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_vld_sr  <= '0;
            r_last_sr <= '0;
        end else begin
            r_vld_sr[0]  <= r_rd_active;
            r_last_sr[0] <= w_rd_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_sr[i]  <= r_vld_sr[i-1];
                r_last_sr[i] <= r_last_sr[i-1];
            end
        end
    end

    // Sticky overflow and rejected-start pulse
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ovf       <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            if (w_drop) r_ovf <= 1'b1;
            r_start_err <= start & ~w_start_ok;
        end
    end

`ifdef ITL_CTRL_STAT_EN
    logic [15:0] r_blk_cnt, r_drop_cnt;

    // Completed-block counter (wraps) and dropped-pair counter (saturates)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_blk_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (done) r_blk_cnt <= r_blk_cnt + 16'd1;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign blk_cnt  = r_blk_cnt;
    assign drop_cnt = r_drop_cnt;
`endif

    assign wr_en     = w_wr_en;
    assign wr_bank   = r_wr_bank;
    assign wr_addr   = r_wr_cnt;
    assign rd_en     = r_rd_active;
    assign rd_bank   = r_rd_bank;
    assign rd_idx    = r_rd_idx;
    assign rd_mode   = r_rd_mode;
    assign dout_vld  = r_vld_sr[RD_LAT-1];
    assign done      = r_vld_sr[RD_LAT-1] & r_last_sr[RD_LAT-1];
    assign ovf       = r_ovf;
    assign start_err = r_start_err;

endmodule
`default_nettype wire

// File: tb/tb_turbo_itl_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_turbo_itl_ctrl
//  Description : Directed self-checking bench for turbo_itl_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_turbo_itl_ctrl;

    localparam int AW     = 12;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [1:0]    pb_size = 2'd0;
    logic          din_vld = 1'b0;
    logic          start = 1'b0;
    logic          mod_int_dint = 1'b0;
    logic          wr_en, wr_bank, rd_en, rd_bank, rd_mode, dout_vld, done, ovf, start_err;
    logic [AW-1:0] wr_addr;
    logic [AW-3:0] rd_idx;
`ifdef ITL_CTRL_STAT_EN
    logic [15:0]   blk_cnt, drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    turbo_itl_ctrl #(.AW(AW), .RD_LAT(RD_LAT)) u_dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .pb_size      (pb_size),
        .din_vld      (din_vld),
        .start        (start),
        .mod_int_dint (mod_int_dint),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .rd_en        (rd_en),
        .rd_bank      (rd_bank),
        .rd_idx       (rd_idx),
        .rd_mode      (rd_mode),
        .dout_vld     (dout_vld),
        .done         (done),
        .ovf          (ovf),
        .start_err    (start_err)
`ifdef ITL_CTRL_STAT_EN
        ,
        .blk_cnt      (blk_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},     wr_en,     0);
        check({tag, "_wr_bank"},   wr_bank,   0);
        check({tag, "_wr_addr"},   wr_addr,   0);
        check({tag, "_rd_en"},     rd_en,     0);
        check({tag, "_rd_bank"},   rd_bank,   0);
        check({tag, "_rd_idx"},    rd_idx,    0);
        check({tag, "_rd_mode"},   rd_mode,   0);
        check({tag, "_dout_vld"},  dout_vld,  0);
        check({tag, "_done"},      done,      0);
        check({tag, "_ovf"},       ovf,       0);
        check({tag, "_start_err"}, start_err, 0);
    endtask

    // Write one PB16 block into the expected bank with consecutive pairs
    task automatic fill_pb16(input string tag, input logic exp_bank);
        for (int i = 0; i < 64; i++) begin
            cyc();
            din_vld = 1'b1;
            pb_size = 2'd0;
            #1;
            check({tag, "_wr_en"},   wr_en,   1);
            check({tag, "_wr_addr"}, wr_addr, i);
            check({tag, "_wr_bank"}, wr_bank, exp_bank);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check_all_zero("reset");
        cyc();
        n_rst = 1'b1;

        // PB16 fill into bank 0, writer moves to bank 1 right after
        fill_pb16("fill0", 1'b0);
        cyc();
        din_vld = 1'b0;
        #1;
        check("fill0_toggle_bank", wr_bank, 1);
        check("fill0_idle_wr_en", wr_en, 0);

        // Interleave read of bank 0; mode latched, a start mid-read is rejected
        cyc();
        start = 1'b1;
        mod_int_dint = 1'b1;
        #1;
        check("rd0_pre_rd_en", rd_en, 0);
        for (int k = 0; k < 19; k++) begin
            cyc();
            start = (k == 3);
            mod_int_dint = 1'b0;
            #1;
            check("rd0_rd_en", rd_en, (k < 16));
            if (k < 16) begin
                check("rd0_rd_idx",  rd_idx,  k);
                check("rd0_rd_bank", rd_bank, 0);
                check("rd0_rd_mode", rd_mode, 1);
            end
            check("rd0_dout_vld",  dout_vld,  (k >= 2 && k < 18));
            check("rd0_done",      done,      (k == 17));
            check("rd0_start_err", start_err, (k == 4));
        end
        start = 1'b0;
`ifdef ITL_CTRL_STAT_EN
        check("rd0_blk_cnt", blk_cnt, 1);
`endif

        // Start with both banks empty
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        check("empty_start_err", start_err, 1);
        check("empty_rd_en",     rd_en,     0);
        cyc();
        #1;
        check("empty_start_err_clr", start_err, 0);
        check("empty_rd_en2",        rd_en,     0);

        // Ping-pong: bank 1 PB16, then PB136 into bank 0 while bank 1 is read
        fill_pb16("fill1", 1'b1);
        for (int i = 0; i < 544; i++) begin
            cyc();
            din_vld = 1'b1;
            pb_size = (i < 100) ? 2'd1 : 2'd0;
            start = (i == 0);
            mod_int_dint = 1'b0;
            #1;
            check("pp_wr_en",   wr_en,   1);
            check("pp_wr_addr", wr_addr, i);
            check("pp_wr_bank", wr_bank, 0);
            if (i >= 1 && i <= 16) begin
                check("pp_rd_en",   rd_en,   1);
                check("pp_rd_idx",  rd_idx,  i - 1);
                check("pp_rd_bank", rd_bank, 1);
                check("pp_rd_mode", rd_mode, 0);
            end
            if (i == 17) check("pp_rd_end", rd_en, 0);
        end
        start = 1'b0;
        cyc();
        din_vld = 1'b0;
        #1;
        check("pp_toggle_bank", wr_bank, 1);
`ifdef ITL_CTRL_STAT_EN
        check("pp_blk_cnt", blk_cnt, 2);
`endif

        // Overflow: bank 0 holds PB136, bank 1 filled, three more pairs dropped
        fill_pb16("fill2", 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            din_vld = 1'b1;
            #1;
            check("ovf_wr_en", wr_en, 0);
            if (i == 0) check("ovf_before", ovf, 0);
        end
        cyc();
        din_vld = 1'b0;
        #1;
        check("ovf_set",       ovf,     1);
        check("ovf_wr_bank",   wr_bank, 1);
`ifdef ITL_CTRL_STAT_EN
        check("ovf_drop_cnt", drop_cnt, 3);
`endif

        // Oldest FULL bank (0) is read first; reset lands at rd_idx 5
        cyc();
        start = 1'b1;
        mod_int_dint = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            start = 1'b0;
            #1;
            if (k == 0) begin
                check("old_rd_en",   rd_en,   1);
                check("old_rd_bank", rd_bank, 0);
                check("old_rd_mode", rd_mode, 1);
            end
            check("old_rd_idx", rd_idx, k);
        end
        check("old_dout_vld", dout_vld, 1);
        #1;
        n_rst = 1'b0;
        #1;
        check_all_zero("midrst");

        // Post-reset: reserved size dropped, then fill restarts at bank 0 address 0
        cyc();
        cyc();
        n_rst = 1'b1;
        cyc();
        din_vld = 1'b1;
        pb_size = 2'd3;
        #1;
        check("rsvd_wr_en", wr_en, 0);
        cyc();
        pb_size = 2'd0;
        #1;
        check("post_wr_en",   wr_en,   1);
        check("post_wr_addr", wr_addr, 0);
        check("post_wr_bank", wr_bank, 0);
        check("rsvd_ovf",     ovf,     1);
        cyc();
        din_vld = 1'b0;
        #1;
        check("post_wr_addr_next", wr_addr, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
